cmd_fetch_mem: RTL

Parametrised command memory with a built-in sequential fetch port, sitting between the host load bus and a processor core's decode stage. The host writes commands in HOST_WIDTH lanes. The core receives full CMD_WIDTH commands through a valid/ready stream that auto-increments a program counter and supports jumps. Read latency is hidden by prefetch, so one command per cycle is sustained. Write-to-fetch hazards are detected and resolved by refetch.

---
 rtl/cmd_mem_pkg.sv | 38 +++
 rtl/cmd_fetch_mem_if.sv | 31 +++
 rtl/cmd_mem_lane.sv | 34 +++
 rtl/cmd_fetch_mem.sv | 92 +++++++++
 4 files changed

// File: rtl/cmd_mem_pkg.sv
// Shared definitions for the command fetch memory: lane geometry derivation
// and address/lane slicing helpers used by the RTL and by benches.
package cmd_mem_pkg;

   localparam int MAX_ADDR_W = 32;
   localparam int MAX_CMD_W  = 1024;
   localparam int MAX_HOST_W = 256;

   function automatic int lanes_of(input int cmd_w, input int host_w);
      return cmd_w / host_w;
   endfunction

   function automatic int lane_bits_of(input int lanes);
      return (lanes <= 1) ? 0 : $clog2(lanes);
   endfunction

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

   // Host addresses carry the word index above the lane index.
   function automatic logic [MAX_ADDR_W-1:0] word_field(input logic [MAX_ADDR_W-1:0] addr,
                                                        input int lane_bits);
      return addr >> lane_bits;
   endfunction

   function automatic int lane_field(input logic [MAX_ADDR_W-1:0] addr, input int lane_bits);
      return int'(addr & ((MAX_ADDR_W'(1) << lane_bits) - MAX_ADDR_W'(1)));
   endfunction

   function automatic logic [MAX_HOST_W-1:0] lane_slice(input logic [MAX_CMD_W-1:0] word,
                                                        input int lane, input int host_w);
      logic [MAX_CMD_W-1:0] mask;
      mask = (host_w >= MAX_HOST_W) ? {MAX_CMD_W{1'b1}} : ((MAX_CMD_W'(1) << host_w) - MAX_CMD_W'(1));
      return MAX_HOST_W'((word >> (lane * host_w)) & mask);
   endfunction

endpackage

// File: rtl/cmd_fetch_mem_if.sv
// Host write bus plus fetch stream of the command memory; master drives
// writes/control and consumes commands, slave is the memory.
interface cmd_fetch_mem_if #(
   parameter int CMD_WIDTH  = 128,
   parameter int HOST_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) ();
   localparam int LANE_BITS =
      cmd_mem_pkg::lane_bits_of(cmd_mem_pkg::lanes_of(CMD_WIDTH, HOST_WIDTH));

   logic                            wr_en;
   logic [ADDR_WIDTH+LANE_BITS-1:0] wr_addr;
   logic [HOST_WIDTH-1:0]           wr_data;
   logic                            enable;
   logic                            pc_load;
   logic [ADDR_WIDTH-1:0]           pc_in;
   logic [CMD_WIDTH-1:0]            cmd_out;
   logic [ADDR_WIDTH-1:0]           cmd_addr;
   logic                            cmd_valid;
   logic                            cmd_ready;

   modport master (
      output wr_en, wr_addr, wr_data, enable, pc_load, pc_in, cmd_ready,
      input  cmd_out, cmd_addr, cmd_valid
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, enable, pc_load, pc_in, cmd_ready,
      output cmd_out, cmd_addr, cmd_valid
   );
endinterface

// File: rtl/cmd_mem_lane.sv
// One HOST_WIDTH-wide lane of command storage: simple dual-port RAM with a
// read-first synchronous read and a synchronously reset output register.
module cmd_mem_lane #(
   parameter int HOST_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [HOST_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [HOST_WIDTH-1:0] rd_data
);
   logic [HOST_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [HOST_WIDTH-1:0] rd_data_reg;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Contents are never cleared; only the output register honours reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_reg <= '0;
      end else begin
         rd_data_reg <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_reg;
endmodule

// File: rtl/cmd_fetch_mem.sv
// Command memory with a prefetching sequential fetch port: the RAM is always
// addressed with next-pc so one command per cycle streams out.
module cmd_fetch_mem
   import cmd_mem_pkg::*;
#(
   parameter int CMD_WIDTH  = 128,
   parameter int HOST_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic           clk,
   input  logic           reset,
   cmd_fetch_mem_if.slave bus
);
   localparam int LANES     = lanes_of(CMD_WIDTH, HOST_WIDTH);
   localparam int LANE_BITS = lane_bits_of(LANES);

   generate
      if (CMD_WIDTH % HOST_WIDTH != 0) begin : g_bad_div
         $fatal(1, "CMD_WIDTH must be an integer multiple of HOST_WIDTH");
      end
      if (!is_pow2(LANES)) begin : g_bad_lanes
         $fatal(1, "CMD_WIDTH/HOST_WIDTH must be a power of two");
      end
      if (ADDR_WIDTH + LANE_BITS > MAX_ADDR_W) begin : g_bad_addr
         $fatal(1, "host address wider than supported");
      end
   endgenerate

   logic [ADDR_WIDTH-1:0] pc_reg;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic                  valid_reg;
   logic                  valid_next;
   logic                  accept;
   logic                  hazard;
   logic [ADDR_WIDTH-1:0] wr_word;
   logic [CMD_WIDTH-1:0]  rd_word;

   assign accept  = valid_reg & bus.cmd_ready;
   assign wr_word = ADDR_WIDTH'(word_field(MAX_ADDR_W'(bus.wr_addr), LANE_BITS));

   always_comb begin
      pc_next = pc_reg;
      if (reset) begin
         pc_next = '0;
      end else if (bus.pc_load) begin
         pc_next = bus.pc_in;
      end else if (accept) begin
         pc_next = pc_reg + ADDR_WIDTH'(1);
      end
   end

   // A write landing on the word being read returns stale data (read-first);
   // drop valid for a cycle so the unchanged pc refetches the updated word.
   assign hazard     = bus.wr_en && (wr_word == pc_next);
   assign valid_next = ~reset & bus.enable & ~hazard;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg    <= '0;
         valid_reg <= 1'b0;
      end else begin
         pc_reg    <= pc_next;
         valid_reg <= valid_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic lane_we;

         assign lane_we = bus.wr_en && (lane_field(MAX_ADDR_W'(bus.wr_addr), LANE_BITS) == gi);

         cmd_mem_lane #(
            .HOST_WIDTH (HOST_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
         ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (lane_we),
            .wr_addr (wr_word),
            .wr_data (bus.wr_data),
            .rd_addr (pc_next),
            .rd_data (rd_word[gi*HOST_WIDTH +: HOST_WIDTH])
         );
      end
   endgenerate

   assign bus.cmd_out   = rd_word;
   assign bus.cmd_addr  = pc_reg;
   assign bus.cmd_valid = valid_reg;
endmodule
